// File: rtl/ahb_lite_cmd_master.sv
// rtl/ahb_lite_cmd_master.sv - AHB-Lite single-transfer master fed from a command FIFO
// The FIFO head drives the address phase directly and is popped when that phase is accepted.
module ahb_lite_cmd_master #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int CMD_DEPTH = 4,
   parameter int ERR_FLUSH = 0
) (
   input  logic                       HCLK,
   input  logic                       HRESET,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_write,
   input  logic [ADDR_W-1:0]          cmd_addr,
   input  logic [DATA_W-1:0]          cmd_wdata,
   input  logic [2:0]                 cmd_size,
   output logic [$clog2(CMD_DEPTH):0] cmd_level,
   output logic                       rsp_valid,
   output logic                       rsp_write,
   output logic                       rsp_err,
   output logic [DATA_W-1:0]          rsp_rdata,
   input  logic                       HREADY,
   input  logic                       HRESP,
   input  logic [DATA_W-1:0]          HRDATA,
   output logic [ADDR_W-1:0]          HADDR,
   output logic                       HWRITE,
   output logic [2:0]                 HSIZE,
   output logic [2:0]                 HBURST,
   output logic [3:0]                 HPROT,
   output logic [1:0]                 HTRANS,
   output logic                       HMASTLOCK,
   output logic [DATA_W-1:0]          HWDATA
);
   localparam int PTR_W = $clog2(CMD_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_ERR} state_t;
   state_t state, state_n;

   logic              mem_write [CMD_DEPTH];
   logic [ADDR_W-1:0] mem_addr  [CMD_DEPTH];
   logic [DATA_W-1:0] mem_wdata [CMD_DEPTH];
   logic [2:0]        mem_size  [CMD_DEPTH];

   logic [PTR_W:0]   wr_ptr, rd_ptr, level_n;
   logic [PTR_W-1:0] wr_idx, rd_idx;
   logic             fifo_empty, fifo_full, push, pop, addr_active;
   logic             dp_valid, dp_valid_n, dp_write, dp_done, flush_rsp;

   assign wr_idx     = wr_ptr[PTR_W-1:0];
   assign rd_idx     = rd_ptr[PTR_W-1:0];
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
   assign cmd_level  = wr_ptr - rd_ptr;
   assign cmd_ready  = !fifo_full && (state != S_ERR);
   assign push       = cmd_valid && cmd_ready;

   // Address phase exists only in ACTIVE; ERR forces IDLE to cancel the pending head.
   assign addr_active = (state == S_ACTIVE) && !fifo_empty;
   assign HTRANS      = addr_active ? 2'b10 : 2'b00;
   assign HADDR       = addr_active ? mem_addr[rd_idx] : '0;
   assign HWRITE      = addr_active ? mem_write[rd_idx] : 1'b0;
   assign HSIZE       = addr_active ? mem_size[rd_idx] : 3'b000;
   assign HBURST      = 3'b000;
   assign HPROT       = 4'b0011;
   assign HMASTLOCK   = 1'b0;

   always_comb begin
      state_n    = state;
      pop        = 1'b0;
      dp_done    = 1'b0;
      flush_rsp  = 1'b0;
      dp_valid_n = dp_valid;
      case (state)
         S_IDLE: begin
            if (push) state_n = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (HREADY) begin
               dp_done    = dp_valid;
               pop        = addr_active;
               dp_valid_n = addr_active;
            end else if (dp_valid && HRESP) begin
               state_n = S_ERR;
            end
         end
         S_ERR: begin
            if (dp_valid) begin
               if (HREADY) begin
                  dp_done    = 1'b1;
                  dp_valid_n = 1'b0;
               end
            end else if (ERR_FLUSH != 0 && !fifo_empty) begin
               pop       = 1'b1;
               flush_rsp = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
      level_n = cmd_level + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      if (state == S_ACTIVE && state_n == S_ACTIVE && level_n == '0 && !dp_valid_n)
         state_n = S_IDLE;
      // Flush mode stays in ERR draining one entry per cycle until the FIFO is empty.
      if (state == S_ERR && !dp_valid_n) begin
         if (ERR_FLUSH == 0)
            state_n = (level_n == '0) ? S_IDLE : S_ACTIVE;
         else if (level_n == '0)
            state_n = S_IDLE;
      end
   end

   always_ff @(posedge HCLK) begin
      if (push) begin
         mem_write[wr_idx] <= cmd_write;
         mem_addr[wr_idx]  <= cmd_addr;
         mem_wdata[wr_idx] <= cmd_wdata;
         mem_size[wr_idx]  <= cmd_size;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         dp_valid  <= 1'b0;
         dp_write  <= 1'b0;
         HWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state    <= state_n;
         dp_valid <= dp_valid_n;
         if (push) wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
         if (pop)  rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
         if (pop && !flush_rsp) begin
            dp_write <= mem_write[rd_idx];
            if (mem_write[rd_idx]) HWDATA <= mem_wdata[rd_idx];
         end
         rsp_valid <= dp_done || flush_rsp;
         if (dp_done) begin
            rsp_write <= dp_write;
            rsp_err   <= HRESP || (state == S_ERR);
            rsp_rdata <= dp_write ? '0 : HRDATA;
         end else if (flush_rsp) begin
            rsp_write <= mem_write[rd_idx];
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
         end
      end
   end
endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// tb/tb_ahb_lite_cmd_master.sv - directed bench for ahb_lite_cmd_master
// Two instances share stimulus: u_dut re-issues after ERROR, u_flush flushes.
module tb_ahb_lite_cmd_master;
   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        cmd_valid, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [2:0]  cmd_size;
   logic        HREADY, HRESP;
   logic [31:0] HRDATA;

   logic        cmd_ready, rsp_valid, rsp_write, rsp_err, HWRITE, HMASTLOCK;
   logic [2:0]  cmd_level, HSIZE, HBURST;
   logic [31:0] rsp_rdata, HADDR, HWDATA;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;

   logic        f_cmd_ready, f_rsp_valid, f_rsp_write, f_rsp_err, f_HWRITE, f_HMASTLOCK;
   logic [2:0]  f_cmd_level, f_HSIZE, f_HBURST;
   logic [31:0] f_rsp_rdata, f_HADDR, f_HWDATA;
   logic [3:0]  f_HPROT;
   logic [1:0]  f_HTRANS;

   int checks = 0;
   int errors = 0;

   always #5 HCLK = ~HCLK;

   ahb_lite_cmd_master #(.ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4), .ERR_FLUSH(0)) u_dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size), .cmd_level(cmd_level),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
      .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA)
   );

   ahb_lite_cmd_master #(.ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4), .ERR_FLUSH(1)) u_flush (
      .HCLK(HCLK), .HRESET(HRESET),
      .cmd_valid(cmd_valid), .cmd_ready(f_cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size), .cmd_level(f_cmd_level),
      .rsp_valid(f_rsp_valid), .rsp_write(f_rsp_write), .rsp_err(f_rsp_err), .rsp_rdata(f_rsp_rdata),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
      .HADDR(f_HADDR), .HWRITE(f_HWRITE), .HSIZE(f_HSIZE), .HBURST(f_HBURST), .HPROT(f_HPROT),
      .HTRANS(f_HTRANS), .HMASTLOCK(f_HMASTLOCK), .HWDATA(f_HWDATA)
   );

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_htrans", HTRANS, 2'b00);       chk("rst_f_htrans", f_HTRANS, 2'b00);
      chk("rst_haddr", HADDR, 0);             chk("rst_hwrite", HWRITE, 0);
      chk("rst_hsize", HSIZE, 0);             chk("rst_hwdata", HWDATA, 0);
      chk("rst_f_hwdata", f_HWDATA, 0);       chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);         chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_level", cmd_level, 0);         chk("rst_f_level", f_cmd_level, 0);
      chk("rst_hburst", HBURST, 3'b000);      chk("rst_hprot", HPROT, 4'b0011);
      chk("rst_hmastlock", HMASTLOCK, 0);     chk("rst_f_hprot", f_HPROT, 4'b0011);
   endtask

   initial begin
      HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_size = 3'b010; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      tick(); tick();
      chk_reset_vals();
      chk("rst_cmd_ready", cmd_ready, 1);
      HRESET = 1'b0;

      // single write
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hA5A5_A5A5;
      tick();
      cmd_valid = 1'b0;
      chk("w1_htrans", HTRANS, 2'b10); chk("w1_haddr", HADDR, 32'h10);
      chk("w1_hwrite", HWRITE, 1);     chk("w1_hsize", HSIZE, 3'b010);
      chk("w1_level", cmd_level, 1);
      tick();
      chk("w1_dp_htrans", HTRANS, 2'b00); chk("w1_hwdata", HWDATA, 32'hA5A5_A5A5);
      chk("w1_no_rsp", rsp_valid, 0);     chk("w1_level0", cmd_level, 0);
      tick();
      chk("w1_rsp_valid", rsp_valid, 1); chk("w1_rsp_err", rsp_err, 0);
      chk("w1_rsp_write", rsp_write, 1); chk("w1_rsp_rdata", rsp_rdata, 0);
      tick();
      chk("w1_rsp_pulse", rsp_valid, 0);

      // four back-to-back reads
      cmd_write = 1'b0;
      for (int i = 0; i < 7; i++) begin
         cmd_valid = (i < 4);
         cmd_addr  = 32'(4 * i);
         HRDATA    = (i >= 2) ? 32'(32'h1000 + 4 * (i - 2)) : 32'h0;
         if (i >= 1 && i <= 4) begin
            chk("b2b_htrans", HTRANS, 2'b10);
            chk("b2b_haddr", HADDR, 32'(4 * (i - 1)));
         end else begin
            chk("b2b_idle", HTRANS, 2'b00);
         end
         chk("b2b_level", cmd_level, (i >= 1 && i <= 4) ? 1 : 0);
         if (i >= 3) begin
            chk("b2b_rsp_valid", rsp_valid, 1);
            chk("b2b_rsp_rdata", rsp_rdata, 32'(32'h1000 + 4 * (i - 3)));
            chk("b2b_rsp_write", rsp_write, 0);
         end else begin
            chk("b2b_no_rsp", rsp_valid, 0);
         end
         tick();
      end
      chk("b2b_rsp_end", rsp_valid, 0);
      chk("b2b_hwdata_kept", HWDATA, 32'hA5A5_A5A5);

      // wait states on a write data phase with a read pending
      for (int i = 0; i < 9; i++) begin
         cmd_valid = (i < 2);
         cmd_write = (i == 0);
         cmd_addr  = (i == 0) ? 32'h30 : 32'h34;
         cmd_wdata = (i == 0) ? 32'h1234_5678 : 32'hDEAD_BEEF;
         HREADY    = !(i >= 2 && i <= 4);
         HRDATA    = 32'h0000_BEEF;
         if (i >= 2 && i <= 5) begin
            chk("ws_htrans", HTRANS, 2'b10);       chk("ws_haddr", HADDR, 32'h34);
            chk("ws_hwdata", HWDATA, 32'h1234_5678); chk("ws_level", cmd_level, 1);
            chk("ws_no_rsp", rsp_valid, 0);
         end
         if (i == 6) begin
            chk("ws_rsp_valid", rsp_valid, 1); chk("ws_rsp_write", rsp_write, 1);
            chk("ws_rsp_err", rsp_err, 0);     chk("ws_level0", cmd_level, 0);
         end
         if (i == 7) begin
            chk("ws_rd_valid", rsp_valid, 1);  chk("ws_rd_write", rsp_write, 0);
            chk("ws_rd_rdata", rsp_rdata, 32'h0000_BEEF);
            chk("ws_hwdata_rd", HWDATA, 32'h1234_5678);
         end
         if (i == 8) chk("ws_rsp_end", rsp_valid, 0);
         tick();
      end

      // FIFO full with the bus stalled
      HREADY = 1'b0; cmd_write = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("full_level", cmd_level, (i < 4) ? i : 4);
         chk("full_ready", cmd_ready, (i < 4) ? 1 : 0);
         cmd_valid = 1'b1;
         cmd_addr  = 32'(32'h40 + 4 * i);
         tick();
      end
      cmd_valid = 1'b0;
      chk("full_level_hold", cmd_level, 4);
      chk("full_ready_hold", cmd_ready, 0);
      for (int j = 0; j < 6; j++) begin
         HREADY = 1'b1;
         HRDATA = (j >= 1) ? 32'(32'h2000 + (j - 1)) : 32'h0;
         if (j <= 3) begin
            chk("full_htrans", HTRANS, 2'b10);
            chk("full_haddr", HADDR, 32'(32'h40 + 4 * j));
         end else begin
            chk("full_idle", HTRANS, 2'b00);
         end
         if (j >= 2) begin
            chk("full_rsp_valid", rsp_valid, 1);
            chk("full_rsp_rdata", rsp_rdata, 32'(32'h2000 + (j - 2)));
         end else begin
            chk("full_no_rsp", rsp_valid, 0);
         end
         tick();
      end
      chk("full_no_5th", rsp_valid, 0);
      chk("full_empty", cmd_level, 0);

      // two-cycle ERROR on write 0x20 with read 0x24 queued behind it
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h55;
      tick();
      cmd_write = 1'b0; cmd_addr = 32'h24;
      chk("err_haddr_w", HADDR, 32'h20); chk("err_f_haddr_w", f_HADDR, 32'h20);
      tick();
      cmd_valid = 1'b0;
      chk("err_haddr_r", HADDR, 32'h24);  chk("err_hwdata", HWDATA, 32'h55);
      chk("err_f_htrans", f_HTRANS, 2'b10);
      HREADY = 1'b0; HRESP = 1'b1;
      tick();
      chk("err_idle", HTRANS, 2'b00);       chk("err_f_idle", f_HTRANS, 2'b00);
      chk("err_ready", cmd_ready, 0);       chk("err_f_ready", f_cmd_ready, 0);
      chk("err_no_rsp", rsp_valid, 0);
      HREADY = 1'b1;
      tick();
      HRESP = 1'b0;
      chk("err_rsp_valid", rsp_valid, 1);   chk("err_rsp_err", rsp_err, 1);
      chk("err_rsp_write", rsp_write, 1);   chk("err_f_rsp_err", f_rsp_err, 1);
      chk("err_f_rsp_valid", f_rsp_valid, 1);
      chk("err_reissue_htrans", HTRANS, 2'b10); chk("err_reissue_haddr", HADDR, 32'h24);
      chk("err_f_still_idle", f_HTRANS, 2'b00); chk("err_f_ready_err", f_cmd_ready, 0);
      chk("err_f_level1", f_cmd_level, 1);
      tick();
      HRDATA = 32'h3333;
      chk("err_dp_no_rsp", rsp_valid, 0);   chk("err_dp_idle", HTRANS, 2'b00);
      chk("err_f_drop_valid", f_rsp_valid, 1); chk("err_f_drop_err", f_rsp_err, 1);
      chk("err_f_drop_write", f_rsp_write, 0); chk("err_f_level0", f_cmd_level, 0);
      chk("err_f_ready_back", f_cmd_ready, 1);
      tick();
      chk("err_rd_valid", rsp_valid, 1);    chk("err_rd_err", rsp_err, 0);
      chk("err_rd_rdata", rsp_rdata, 32'h3333);
      chk("err_f_single", f_rsp_valid, 0);
      tick();

      // reset with a data phase in flight and two commands queued
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h77;
      tick();
      cmd_write = 1'b0; cmd_addr = 32'h54;
      tick();
      cmd_addr = 32'h58; HREADY = 1'b0;
      tick();
      cmd_valid = 1'b0;
      chk("mr_level", cmd_level, 2);  chk("mr_haddr", HADDR, 32'h54);
      chk("mr_hwdata", HWDATA, 32'h77);
      HRESET = 1'b1;
      tick();
      chk_reset_vals();
      HRESET = 1'b0; HREADY = 1'b1;
      tick();
      chk("mr_ready", cmd_ready, 1);   chk("mr_f_ready", f_cmd_ready, 1);
      chk("mr_no_rsp", rsp_valid, 0);  chk("mr_f_no_rsp", f_rsp_valid, 0);
      chk("mr_idle", HTRANS, 2'b00);   chk("mr_level0", cmd_level, 0);
      tick();
      chk("mr_no_rsp2", rsp_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
